// File: rtl/dtfm.sv
// dtfm: receive-side frame synchroniser for the dCLK/dFM/dDAT telemetry link; FRM flags frame lock.
// Optional feature macro DTFM_SYNCWORD_CHECK_EN: word 0 of each frame must also equal the 0x5555 sync pattern.
module dtfm #(
    parameter int unsigned WORD_BITS   = 16,
    parameter int unsigned FRAME_WORDS = 640,
    parameter int unsigned MISS_LIMIT  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic dCLK,
    input  logic dFM,
    input  logic dDAT,
    output logic FRM
);
    localparam int unsigned FRAME_BITS = WORD_BITS * FRAME_WORDS;
    localparam int unsigned IW         = $clog2(FRAME_BITS);
    localparam int unsigned MW         = $clog2(MISS_LIMIT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] clk_s, fm_s, dat_s;
    logic                   clk_d, en, smp_fm, smp_dat;

    state_t               state;
    logic [IW-1:0]        idx, cur;
    logic [MW-1:0]        miss, miss_inc;
    logic                 miss_hit;
    logic [WORD_BITS-1:0] sr, sr_nxt;
    logic                 frame_miss, frame_ok, word_bad;
    logic                 unused_sr_msb;

    // Link inputs are resynchronised, then sampled one clk after the synchronised falling edge of dCLK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s   <= '0;
            fm_s    <= '0;
            dat_s   <= '0;
            clk_d   <= 1'b0;
            en      <= 1'b0;
            smp_fm  <= 1'b0;
            smp_dat <= 1'b0;
        end else begin
            clk_s   <= SYNC_STAGES'({clk_s, dCLK});
            fm_s    <= SYNC_STAGES'({fm_s, dFM});
            dat_s   <= SYNC_STAGES'({dat_s, dDAT});
            clk_d   <= clk_s[SYNC_STAGES-1];
            en      <= clk_d & ~clk_s[SYNC_STAGES-1];
            smp_fm  <= fm_s[SYNC_STAGES-1];
            smp_dat <= dat_s[SYNC_STAGES-1];
        end
    end

`ifdef DTFM_SYNCWORD_CHECK_EN
    localparam logic [63:0]          SYNC_PAT  = {8{8'h55}};
    localparam logic [WORD_BITS-1:0] SYNC_WORD = SYNC_PAT[WORD_BITS-1:0];
    localparam logic [IW-1:0]        WORD0_END = IW'(WORD_BITS - 1);
    logic mk_seen;
`endif

    // idx holds the position of the previous sample; cur is the position of the one being taken now.
    always_comb begin
        cur      = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        sr_nxt   = {sr[WORD_BITS-2:0], smp_dat};
        miss_inc = miss + MW'(1);
        miss_hit = (32'(miss) + 32'd1) >= MISS_LIMIT;
`ifdef DTFM_SYNCWORD_CHECK_EN
        // The miss counter clears only once marker and sync word of a frame are both good.
        word_bad   = (cur == WORD0_END) && (sr_nxt != SYNC_WORD);
        frame_miss = ((cur == '0) && !smp_fm) || (mk_seen && word_bad);
        frame_ok   = mk_seen && (cur == WORD0_END) && !word_bad;
`else
        word_bad   = 1'b0;
        frame_miss = (cur == '0) && !smp_fm;
        frame_ok   = (cur == '0) && smp_fm;
`endif
    end

    assign unused_sr_msb = sr[WORD_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
            idx   <= '0;
            miss  <= '0;
            sr    <= '0;
            FRM   <= 1'b0;
`ifdef DTFM_SYNCWORD_CHECK_EN
            mk_seen <= 1'b0;
`endif
        end else if (en) begin
            idx <= cur;
            sr  <= sr_nxt;
            case (state)
                SEARCH: begin
                    if (smp_fm) begin
                        idx   <= '0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (cur == '0) begin
                        if (smp_fm) begin
                            state <= LOCKED;
                            FRM   <= 1'b1;
                            miss  <= '0;
`ifdef DTFM_SYNCWORD_CHECK_EN
                            mk_seen <= 1'b1;
`endif
                        end else begin
                            state <= SEARCH;
                        end
                    end else if (smp_fm) begin
                        idx <= '0;
                    end else if (word_bad) begin
                        state <= SEARCH;
                    end
                end
                LOCKED: begin
                    if ((cur != '0) && smp_fm) begin
                        idx   <= '0;
                        miss  <= '0;
                        state <= CHECK;
                        FRM   <= 1'b0;
                    end else if (frame_miss) begin
                        if (miss_hit) begin
                            miss  <= '0;
                            state <= SEARCH;
                            FRM   <= 1'b0;
                        end else begin
                            miss <= miss_inc;
                        end
                    end else if (frame_ok) begin
                        miss <= '0;
                    end
`ifdef DTFM_SYNCWORD_CHECK_EN
                    if (cur == '0) mk_seen <= smp_fm;
`endif
                end
                default: begin
                    state <= SEARCH;
                    FRM   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dtfm.sv
// Bench for dtfm: randomized link stream against a frame-level reference model, with a shortened frame.
module tb_dtfm;
    localparam int WB = 16;
    localparam int FW = 4;
    localparam int FB = WB * FW;
    localparam int ML = 2;
    localparam logic [15:0] SYNC_WORD = 16'h5555;
`ifdef DTFM_SYNCWORD_CHECK_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif
    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst, dCLK, dFM, dDAT, FRM;
    int compared = 0;
    int mismatched = 0;

    int          m_mode;
    int          m_n = 0;
    int          m_anchor = 0;
    int          m_miss;
    bit          m_mk;
    logic [15:0] m_word;
    logic        m_frm;

    always #5 clk = ~clk;

    dtfm #(.WORD_BITS(WB), .FRAME_WORDS(FW), .MISS_LIMIT(ML), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .dCLK(dCLK), .dFM(dFM), .dDAT(dDAT), .FRM(FRM)
    );

    function automatic void model_reset();
        m_mode = M_SEARCH;
        m_miss = 0;
        m_mk   = 1'b0;
        m_word = '0;
        m_frm  = 1'b0;
    endfunction

    function automatic void model_miss();
        m_miss++;
        if (m_miss >= ML) begin
            m_miss = 0;
            m_mode = M_SEARCH;
        end
    endfunction

    // Frame position is measured from the absolute sample number of the last accepted marker.
    function automatic void model_sample(input logic fm, input logic dat);
        int pos;
        m_n++;
        m_word = {m_word[14:0], dat};
        pos = (m_n - m_anchor) % FB;
        if (m_mode == M_SEARCH) begin
            if (fm) begin m_mode = M_CHECK; m_anchor = m_n; end
        end else if (m_mode == M_CHECK) begin
            if (fm && pos == 0) begin m_mode = M_LOCKED; m_miss = 0; m_mk = 1'b1; end
            else if (fm) m_anchor = m_n;
            else if (pos == 0) m_mode = M_SEARCH;
            else if (SYNC_EN && pos == WB - 1 && m_word != SYNC_WORD) m_mode = M_SEARCH;
        end else begin
            if (pos == 0) begin
                m_mk = fm;
                if (!fm) model_miss();
                else if (!SYNC_EN) m_miss = 0;
            end else if (fm) begin
                m_mode = M_CHECK; m_anchor = m_n; m_miss = 0;
            end else if (SYNC_EN && pos == WB - 1 && m_mk) begin
                if (m_word == SYNC_WORD) m_miss = 0;
                else model_miss();
            end
        end
        m_frm = (m_mode == M_LOCKED);
    endfunction

    function automatic void gen_bit(input int b, input bit marker, input int extra,
                                    input logic [15:0] w0, output logic fm, output logic dat);
        fm  = (b == 0 && marker) || (extra > 0 && b == extra);
        dat = (b < 16) ? w0[15-b] : 1'($urandom);
    endfunction

    // One 16-clk bit: 8 clk high then 8 low; FRM sampled 4 clk after the fall and again at bit end.
    task automatic send_bit(input logic fm, input logic dat, output logic obs_a, output logic obs_b);
        @(posedge clk); #2;
        dCLK = 1'b1; dFM = fm; dDAT = dat;
        repeat (8) @(posedge clk);
        #2 dCLK = 1'b0;
        model_sample(fm, dat);
        repeat (4) @(posedge clk);
        #2 obs_a = FRM;
        repeat (3) @(posedge clk);
        #1 obs_b = FRM;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic fm, dat, oa, ob;
        rst = 1'b1; dCLK = 1'b0; dFM = 1'b0; dDAT = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (FRM !== 1'b0) begin mismatched++; $display("FAIL reset_value: FRM=%b expected 0", FRM); end
        rst = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL reset_lock f%0d b%0d: FRM=%b%b expected %b", f, b, oa, ob, m_frm); end
            end
        compared++;
        if (FRM !== 1'b1) begin mismatched++; $display("FAIL reset_prelock: FRM=%b expected 1", FRM); end
        for (int b = 0; b < 20; b++) begin
            gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
            send_bit(fm, dat, oa, ob);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (FRM !== 1'b0) begin mismatched++; $display("FAIL reset_async: FRM=%b expected 0", FRM); end
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int b = 20; b < 3 * FB; b++) begin
            gen_bit(b % FB, 1'b1, 0, SYNC_WORD, fm, dat);
            send_bit(fm, dat, oa, ob);
            compared++;
            if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL reset_relock b%0d: FRM=%b%b expected %b", b, oa, ob, m_frm); end
            if (b == 2 * FB - 1) begin
                compared++;
                if (ob !== 1'b0) begin mismatched++; $display("FAIL reset_one_marker: FRM=%b expected 0", ob); end
            end
        end
    endtask

    task automatic test_acquire();
        logic fm, dat, oa, ob;
        pulse_reset();
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL acquire f%0d b%0d: FRM=%b%b expected %b", f, b, oa, ob, m_frm); end
                if (f == 1 && b == 0) begin
                    compared++;
                    if (oa !== 1'b1) begin mismatched++; $display("FAIL acquire_latency: FRM=%b expected 1", oa); end
                end
            end
    endtask

    task automatic test_steady();
        logic fm, dat, oa, ob;
        for (int f = 0; f < 15; f++)
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== 2'b11) begin mismatched++; $display("FAIL steady f%0d b%0d: FRM=%b%b expected 11", f, b, oa, ob); end
            end
    endtask

    task automatic test_miss();
        logic fm, dat, oa, ob;
        bit marks [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, marks[f], 0, SYNC_WORD, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL miss f%0d b%0d: FRM=%b%b expected %b", f, b, oa, ob, m_frm); end
            end
            if (f == 0) begin
                compared++;
                if (FRM !== 1'b1) begin mismatched++; $display("FAIL miss_one: FRM=%b expected 1", FRM); end
            end
            if (f == 3) begin
                compared++;
                if (FRM !== 1'b0) begin mismatched++; $display("FAIL miss_two: FRM=%b expected 0", FRM); end
            end
        end
    endtask

    task automatic test_misalign();
        logic fm, dat, oa, ob;
        for (int b = 0; b < 40; b++) begin
            gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
            send_bit(fm, dat, oa, ob);
            compared++;
            if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL misalign_pre b%0d: FRM=%b%b expected %b", b, oa, ob, m_frm); end
        end
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL misalign f%0d b%0d: FRM=%b%b expected %b", f, b, oa, ob, m_frm); end
                if (b == 0 && f < 2) begin
                    compared++;
                    if (oa !== (f == 1)) begin mismatched++; $display("FAIL misalign_edge f%0d: FRM=%b expected %b", f, oa, (f == 1)); end
                end
            end
    endtask

`ifdef DTFM_SYNCWORD_CHECK_EN
    task automatic test_syncword();
        logic fm, dat, oa, ob;
        pulse_reset();
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, 1'b1, 0, 16'h5554, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== 2'b00) begin mismatched++; $display("FAIL sync_bad f%0d b%0d: FRM=%b%b expected 00", f, b, oa, ob); end
            end
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, 1'b1, 0, SYNC_WORD, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL sync_good f%0d b%0d: FRM=%b%b expected %b", f, b, oa, ob, m_frm); end
            end
        compared++;
        if (FRM !== 1'b1) begin mismatched++; $display("FAIL sync_lock: FRM=%b expected 1", FRM); end
    endtask
`endif

    task automatic test_random();
        logic fm, dat, oa, ob;
        bit marker;
        int extra;
        logic [15:0] w0;
        for (int f = 0; f < 15; f++) begin
            marker = ($urandom_range(0, 99) < 80);
            extra  = ($urandom_range(0, 99) < 8) ? int'($urandom_range(1, FB - 1)) : 0;
            w0     = ($urandom_range(0, 99) < 85) ? SYNC_WORD : 16'($urandom);
            for (int b = 0; b < FB; b++) begin
                gen_bit(b, marker, extra, w0, fm, dat);
                send_bit(fm, dat, oa, ob);
                compared++;
                if ({oa, ob} !== {2{m_frm}}) begin mismatched++; $display("FAIL random f%0d b%0d: FRM=%b%b expected %b", f, b, oa, ob, m_frm); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_steady();
        test_miss();
        test_misalign();
`ifdef DTFM_SYNCWORD_CHECK_EN
        test_syncword();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
